// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer built from 4:1 stages, one register level per stage,
// with valid/ready flow control, auto-scan channel select and per-word channel tag.
module mux_tree_pipe #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [(WIDTH<<SEL_W)-1:0]   in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        scan_en,
    input  logic [SEL_W-1:0]            sel,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_sel,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int NUM_IN = 2 ** SEL_W;
    localparam int LEVELS = SEL_W / 2;

    // Nodes of all levels are packed into one array; this gives each level's base offset.
    function automatic int levelOff(input int lvl);
        int off;
        off = 0;
        for (int k = 0; k < lvl; k++) begin
            off += NUM_IN >> (2 * (k + 1));
        end
        return off;
    endfunction

    localparam int NODES = levelOff(LEVELS);

    function automatic logic [WIDTH-1:0] mux4(
        input logic [1:0]       s,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH-1:0] r;
        r = a;
        case (s)
            2'd0: r = a;
            2'd1: r = b;
            2'd2: r = c;
            2'd3: r = d;
            default: r = a;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] node_q [NODES];
    logic [WIDTH-1:0] node_d [NODES];
    logic [SEL_W-1:0] sel_q  [LEVELS];
    logic [LEVELS-1:0] vld_q;
    logic [SEL_W-1:0] scan_cnt_q;
    logic [SEL_W-1:0] scan_cnt_d;
    logic [SEL_W-1:0] esel;
    logic             adv;
    logic             accept;

    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;
    assign accept   = in_valid && in_ready;
    assign esel     = scan_en ? scan_cnt_q : sel;

    for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
        localparam int OFF    = levelOff(j);
        localparam int GROUPS = NUM_IN >> (2 * (j + 1));
        for (genvar g = 0; g < GROUPS; g++) begin : g_grp
            if (j == 0) begin : g_leaf
                assign node_d[OFF+g] = mux4(esel[1:0],
                                            in_data[(4*g+0)*WIDTH +: WIDTH],
                                            in_data[(4*g+1)*WIDTH +: WIDTH],
                                            in_data[(4*g+2)*WIDTH +: WIDTH],
                                            in_data[(4*g+3)*WIDTH +: WIDTH]);
            end else begin : g_inner
                // Deeper levels steer with the select captured alongside the word, not the live one.
                localparam int PREV = levelOff(j - 1);
                assign node_d[OFF+g] = mux4(sel_q[j-1][2*j +: 2],
                                            node_q[PREV+4*g+0],
                                            node_q[PREV+4*g+1],
                                            node_q[PREV+4*g+2],
                                            node_q[PREV+4*g+3]);
            end
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q;
        if (!scan_en) begin
            scan_cnt_d = '0;
        end else if (accept) begin
            scan_cnt_d = scan_cnt_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
        end
    end

    // Whole pipeline moves as one on adv, so a stall freezes bubbles as well as data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NODES; n++) begin
                node_q[n] <= '0;
            end
            for (int l = 0; l < LEVELS; l++) begin
                sel_q[l] <= '0;
            end
            vld_q <= '0;
        end else if (adv) begin
            for (int n = 0; n < NODES; n++) begin
                node_q[n] <= node_d[n];
            end
            sel_q[0] <= esel;
            vld_q[0] <= accept;
            for (int l = 1; l < LEVELS; l++) begin
                sel_q[l] <= sel_q[l-1];
                vld_q[l] <= vld_q[l-1];
            end
        end
    end

    assign out_data  = node_q[NODES-1];
    assign out_sel   = sel_q[LEVELS-1];
    assign out_valid = vld_q[LEVELS-1];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Randomised and directed checks of mux_tree_pipe against a delay-line scoreboard model.
module tb_mux_tree_pipe;

    localparam int WIDTH  = 8;
    localparam int SEL_W  = 4;
    localparam int NUM_IN = 16;
    localparam int LEVELS = 2;

    logic                      clk;
    logic                      rst;
    logic [NUM_IN*WIDTH-1:0]   in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic                      scan_en;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      out_ready;

    mux_tree_pipe #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .scan_en   (scan_en),
        .sel       (sel),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             v;
        logic [SEL_W-1:0] ch;
        logic [WIDTH-1:0] d;
    } slot_t;

    // Model: words accepted are seen LEVELS advancing cycles later; scan counter kept as an int.
    slot_t            pipeQ[$];
    int               scanCnt;
    logic [WIDTH-1:0] chanData [NUM_IN];
    int               checks;
    int               errors;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        slot_t empty;
        empty = '0;
        pipeQ.delete();
        for (int i = 0; i < LEVELS; i++) pipeQ.push_back(empty);
        scanCnt = 0;
    endtask

    task automatic applyStimulus(input bit iv, input bit se, input logic [SEL_W-1:0] s, input bit ordy);
        bit               expValid;
        bit               expReady;
        bit               acc;
        logic [SEL_W-1:0] es;
        slot_t            nw;
        @(negedge clk);
        in_valid  = iv;
        scan_en   = se;
        sel       = s;
        out_ready = ordy;
        for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = chanData[k];
        #1;
        expValid = pipeQ[0].v;
        expReady = ordy || !expValid;
        checkOutput("in_ready", 32'(in_ready), 32'(expReady));
        checkOutput("out_valid", 32'(out_valid), 32'(expValid));
        if (expValid) begin
            checkOutput("out_sel", 32'(out_sel), 32'(pipeQ[0].ch));
            checkOutput("out_data", 32'(out_data), 32'(pipeQ[0].d));
        end
        acc = iv && expReady;
        if (expReady) begin
            es    = se ? SEL_W'(scanCnt) : s;
            nw.v  = acc;
            nw.ch = es;
            nw.d  = chanData[es];
            void'(pipeQ.pop_front());
            pipeQ.push_back(nw);
        end
        if (!se) scanCnt = 0;
        else if (acc) scanCnt = (scanCnt + 1) % NUM_IN;
        @(posedge clk);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        scan_en   = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        for (int k = 0; k < NUM_IN; k++) chanData[k] = 8'h10 + 8'(k);
        for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = chanData[k];
        modelReset();
        #3;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_sel", 32'(out_sel), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;

        // Manual select of channel 9, single word.
        applyStimulus(1, 0, 4'd9, 1);
        applyStimulus(0, 0, 4'd0, 1);
        #1;
        checkOutput("t1_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_data", 32'(out_data), 32'h19);
        checkOutput("t1_sel", 32'(out_sel), 32'd9);
        applyStimulus(0, 0, 4'd0, 1);
        applyStimulus(0, 0, 4'd0, 1);

        // Auto-scan across the wrap point.
        for (int c = 0; c < 18; c++) applyStimulus(1, 1, 4'd0, 1);
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 4'd0, 1);

        // Stall three cycles while channel 5 is presented.
        begin
            int stallLeft;
            stallLeft = 3;
            for (int c = 0; c < 20; c++) begin
                bit ordy;
                ordy = 1'b1;
                if (stallLeft > 0 && pipeQ[0].v && pipeQ[0].ch == 4'd5) begin
                    ordy = 1'b0;
                    stallLeft--;
                end
                applyStimulus(1, 1, 4'd0, ordy);
            end
        end
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 4'd0, 1);

        // Bubbles between manual selects.
        applyStimulus(1, 0, 4'd3, 1);
        applyStimulus(0, 0, 4'd7, 1);
        applyStimulus(1, 0, 4'd12, 1);
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 4'd0, 1);

        // Asynchronous reset with words in flight and a stalled consumer.
        applyStimulus(1, 1, 4'd0, 1);
        applyStimulus(1, 1, 4'd0, 1);
        applyStimulus(1, 1, 4'd0, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_out_data", 32'(out_data), 32'd0);
        checkOutput("t5_out_sel", 32'(out_sel), 32'd0);
        checkOutput("t5_in_ready", 32'(in_ready), 32'd1);
        modelReset();
        @(posedge clk);
        #2 rst = 1'b0;
        applyStimulus(1, 1, 4'd9, 1);
        applyStimulus(1, 1, 4'd9, 1);
        #1;
        checkOutput("t5_first_valid", 32'(out_valid), 32'd1);
        checkOutput("t5_first_sel", 32'(out_sel), 32'd0);
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 4'd0, 1);

        // Scan restart after scan_en drops for one cycle.
        for (int c = 0; c < 7; c++) applyStimulus(1, 1, 4'd0, 1);
        applyStimulus(0, 0, 4'd0, 1);
        applyStimulus(1, 1, 4'd0, 1);
        applyStimulus(0, 1, 4'd0, 1);
        #1;
        checkOutput("t6_restart_sel", 32'(out_sel), 32'd0);
        checkOutput("t6_restart_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 4'd0, 1);

        // Random traffic with back-pressure, changing data and occasional mode flips.
        begin
            bit se;
            se = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 15) == 0) se = ~se;
                if ($urandom_range(0, 3) == 0) begin
                    for (int k = 0; k < NUM_IN; k++) chanData[k] = 8'($urandom);
                end
                applyStimulus(bit'($urandom_range(0, 3) != 0), se,
                              SEL_W'($urandom_range(0, NUM_IN - 1)),
                              bit'($urandom_range(0, 9) < 7));
            end
        end
        for (int c = 0; c < 4; c++) applyStimulus(0, 0, 4'd0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 multiplexer. Built as a tree of 4:1 select stages with one register stage per tree level.
- Adds a valid/ready handshake with global stall, and an auto-scan mode in which an internal counter walks the channels in order.
- Every output word is tagged with the channel index it came from.
- Sits between multi-channel sources (sensor/status banks) and a single-lane consumer.

Parameters:
- WIDTH, 8, bits per channel.
- SEL_W, 4, select width. Must be even and >= 2. NUM_IN = 2**SEL_W channels.
- LEVELS, SEL_W/2, derived. Number of 4:1 tree levels, which equals pipeline latency in cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  1  request to sample in_data this cycle.
- in_ready  output  1  pipeline can accept this cycle.
- scan_en  input  1  1 = auto-scan select, 0 = use sel.
- sel  input  SEL_W  manual channel select.
- out_data  output  WIDTH  selected channel data.
- out_sel  output  SEL_W  channel index of out_data.
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  consumer accepts this cycle.

Behaviour:
- Effective select at accept:
  - scan_en=1: esel = scan_cnt.
  - scan_en=0: esel = sel.
- Accept condition: in_valid && in_ready.
- in_ready = out_ready || !out_valid. This is combinational, and it is also the global pipeline enable `adv`.
- Level 0, on adv:
  - Per group g of 4 channels, registers in_data[channel 4g + esel[1:0]].
  - Registers esel.
  - Registers valid = accept.
- Level j (1..LEVELS-1), on adv:
  - Does a 4:1 select over the previous level using esel[2j+1:2j].
  - Propagates esel and the valid bit.
- The last level drives out_data, out_sel and out_valid directly. There is no extra output register.
- Latency: LEVELS cycles from accept to out_valid when there is no stall. Throughput is 1 word per cycle.
- Bubbles (accept=0) advance as invalid slots while adv=1.
- Stall: out_valid && !out_ready forces adv=0.
  - All stages hold, including bubbles.
  - out_data and out_sel stay stable until the handshake completes.
- scan_cnt (SEL_W bits):
  - Held at 0 while scan_en=0.
  - While scan_en=1, increments by 1 on each accept and wraps from NUM_IN-1 to 0.
  - No change on cycles with no accept.
  - When scan_en goes 0 and then 1 again, the scan restarts at channel 0.
- Switching scan_en or sel mid-stream affects only words accepted from that cycle on. In-flight words keep their captured select and tag.
- Reset (asynchronous, on rst=1, immediate):
  - All stage data, select and valid registers go to 0, and scan_cnt goes to 0.
  - Outputs: out_valid=0, out_data=0, out_sel=0.
  - in_ready=1, because out_valid=0.
  - Words in flight at reset are discarded. First accept after release emerges LEVELS cycles later.
- Width rule: no arithmetic on data. The channel index is unsigned SEL_W bits, and wrap is modulo NUM_IN.

Test Plan:
1. Manual select
   - Stimulus: WIDTH=8, SEL_W=4; channel k holds 8'h10+k; scan_en=0, sel=4'd9, in_valid=1, out_ready=1 for 1 cycle.
   - Response: after 2 cycles, out_valid=1, out_data=8'h19, out_sel=9, for exactly one cycle.
2. Auto-scan wrap
   - Stimulus: scan_en=1, in_valid=1, out_ready=1 for 18 cycles.
   - Response: out_sel sequence 0,1,…,15,0,1 starting at cycle 2; out_data=8'h10+out_sel each cycle.
3. Stall
   - Stimulus: streaming scan; drop out_ready for 3 cycles while out_sel=5.
   - Response: out_data=8'h15 and out_sel=5 held; in_ready=0; scan_cnt frozen; no word lost or duplicated after release (next out_sel=6).
4. Bubbles
   - Stimulus: in_valid pattern 1,0,1 with sel 3,x,12.
   - Response: out_valid pattern 1,0,1 with out_sel 3,12.
5. Reset mid-flight
   - Stimulus: assert rst asynchronously while 2 words are in flight.
   - Response: out_valid=0, out_data=0 and out_sel=0 immediately, without waiting for a clock edge; with scan_en=1 after release, first output is channel 0.
6. Scan restart
   - Stimulus: scan through channels 0..6, deassert scan_en for 1 cycle, reassert.
   - Response: next scanned out_sel=0.
